idma_desc64_desc_decoder: RTL and testbench
===========================================

# idma_desc64_desc_decoder

Downstream of the desc64 descriptor-fetch AXI read port and upstream of the iDMA backend. Collects the four 64-bit beats of one 32-byte descriptor from the R channel, decodes them into an `idma_req_t` for the backend, and hands the next-descriptor pointer back to the fetch logic. Bad or malformed fetches are dropped with an error pulse. One descriptor is in flight at a time.

## Interface
- `AddrWidth`, 64, address width; must be 64.
- `DataWidth`, 64, R-channel data width; must be 64.
- `TFLenWidth`, 32, transfer length width; must be ≤ 32.
- `idma_req_t`, logic, backend request type (`IDMA_TYPEDEF_FULL_REQ_T`).
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; one clock, synchronous, active-high.
- `r_data_i`  in  64  R beat data.
- `r_last_i`  in  1  R beat last.
- `r_err_i`  in  1  RRESP not OKAY on this beat.
- `r_valid_i`  in  1  beat valid.
- `r_ready_o`  out  1  beat accept.
- `idma_req_o`  out  `idma_req_t`  decoded backend request.
- `idma_req_valid_o`  out  1  request valid.
- `idma_req_ready_i`  in  1  backend accepts.
- `irq_en_o`  out  1  IRQ flag of the current descriptor; valid with `idma_req_valid_o`.
- `next_addr_o`  out  64  next-descriptor pointer.
- `next_valid_o`  out  1  pointer valid.
- `next_ready_i`  in  1  fetch logic accepts.
- `chain_end_o`  out  1  level; current descriptor's next pointer is all-ones.
- `fetch_err_o`  out  1  one-cycle pulse; descriptor discarded.

## Operation
- Descriptor layout, beat 0 to 3:
  - beat 0: `[31:0]` length, `[63:32]` flags.
  - beat 1: next pointer.
  - beat 2: source address.
  - beat 3: destination address.
- Flags:
  - bit 0 → `irq_en_o`.
  - bit 1 → `opt.beo.decouple_rw`.
  - bit 2 → `opt.beo.decouple_aw`.
  - bit 3 → `opt.src.burst`/`opt.dst.burst` FIXED when set, INCR otherwise.
  - bits `[31:4]` are ignored.
  - All other `opt` fields are 0 / AXI protocol.
- Length is truncated to `TFLenWidth`.
- FSM states:
  - COLLECT: `r_ready_o`=1. A 2-bit beat counter advances on each accepted beat, and the beat is stored into its slot. An error flag is sticky when `r_err_i`=1, or when `r_last_i`=1 on beats 0–2. On beat 3:
    - `r_last_i`=0 → set error, go to DRAIN.
    - Error flag set → pulse `fetch_err_o`, clear counter and flag, stay in COLLECT.
    - Otherwise → ISSUE.
    - If `r_last_i` arrives early (beats 0–2), the error is flagged, the counter resets and the FSM stays in COLLECT; the error pulse fires on that beat.
  - DRAIN: `r_ready_o`=1, beats discarded. On the beat with `r_last_i`=1, pulse `fetch_err_o` and go to COLLECT.
  - ISSUE: `r_ready_o`=0.
    - `idma_req_valid_o`=1 until handshake.
    - `next_valid_o`=1 until handshake, unless the next pointer is all-ones (`chain_end_o`=1, no next handshake).
    - Each handshake is tracked by its own done bit; the two may complete in either order or the same cycle.
    - Go to COLLECT in the cycle after both are done.
- Valids never drop without handshake; data is stable while valid.

## Timing
- Reset values: all outputs 0; `r_ready_o` goes to 1 the first cycle after reset deasserts; FSM in COLLECT, counter 0.
- Latency: the first cycle of ISSUE, with valids asserted, immediately follows the beat-3 accept; outputs are registered.
- Peak throughput: one descriptor per 5 cycles (4 beats + 1 issue cycle with both readies high).
- Reset mid-descriptor: partial beats are dropped with no error pulse; pending valids drop.

## Configuration
- `IDMA_DESC64_ZERO_LEN_SKIP_EN`: when defined, a descriptor with length 0 raises no `idma_req_valid_o`; its request done bit is preset in ISSUE and only the next-pointer handshake is performed (if not end of chain, otherwise ISSUE lasts one cycle). `irq_en_o` is still driven for that cycle.
- Without the macro, zero-length requests are forwarded unchanged.

## Structure
- Shared package `idma_desc64_pkg`: descriptor beat indices, flag bit positions, end-of-chain constant (all-ones), FSM state enum.
- `idma_req_t` comes from the existing desc64 package typedefs.
- No sub-module; single FSM + beat register file.

## Test plan
- Clean descriptor {len=0x40, flags=0x1, next=0x1000, src=0x2000, dst=0x3000}, readies high → ISSUE after beat 3, req length 0x40, src 0x2000, dst 0x3000, `irq_en_o`=1, `next_addr_o`=0x1000, back in COLLECT in 1 cycle.
- Next pointer 0xFFFF_FFFF_FFFF_FFFF → `chain_end_o`=1, `next_valid_o` never asserts, request still issues.
- `r_err_i` on beat 2 → no valid asserted, `fetch_err_o` pulses on the beat-3 accept cycle; the following clean descriptor decodes correctly.
- Five beats (last on beat 4) → DRAIN, `fetch_err_o` on beat 4, no request; next descriptor OK.
- Backend ready held low 10 cycles, `next_ready_i` high → next handshake done at once, request stays valid and stable, `r_ready_o`=0 until request accepted.
- Zero-length descriptor, with and without `IDMA_DESC64_ZERO_LEN_SKIP_EN` → request suppressed vs forwarded; next pointer handed over in both cases.

Source files
------------

// File: rtl/idma_desc64_pkg.sv
// Shared definitions for the desc64 descriptor decoder: beat slot indices,
// flag bit positions, the end-of-chain pointer value, the backend request
// typedefs and the decoder FSM state encoding.
package idma_desc64_pkg;

    // A descriptor is four 64-bit beats; beat 3 is never stored, it is
    // decoded straight off the bus in the cycle it is accepted.
    localparam int unsigned DESC_BEATS = 4;
    localparam int unsigned BEAT_LEN   = 0;
    localparam int unsigned BEAT_NEXT  = 1;
    localparam int unsigned BEAT_SRC   = 2;
    localparam int unsigned BEAT_DST   = 3;
    localparam logic [1:0]  BEAT_LAST_IDX = 2'd3;

    // Flags occupy the upper word of beat 0.
    localparam int unsigned FLAGS_LSB         = 32;
    localparam int unsigned FLAG_IRQ          = 0;
    localparam int unsigned FLAG_DECOUPLE_RW  = 1;
    localparam int unsigned FLAG_DECOUPLE_AW  = 2;
    localparam int unsigned FLAG_BURST_FIXED  = 3;
    localparam int unsigned FLAGS_USED        = 4;

    // A next pointer of all ones terminates the chain.
    localparam logic [63:0] END_OF_CHAIN = '1;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    typedef enum logic [2:0] {
        PROT_AXI = 3'd0
    } protocol_e;

    typedef struct packed {
        logic [1:0] burst;
        logic [3:0] cache;
        logic       lock;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
    } axi_opt_t;

    typedef struct packed {
        logic       decouple_aw;
        logic       decouple_rw;
        logic [2:0] src_max_llen;
        logic [2:0] dst_max_llen;
        logic       src_reduce_len;
        logic       dst_reduce_len;
    } backend_opt_t;

    typedef struct packed {
        protocol_e    src_protocol;
        protocol_e    dst_protocol;
        logic [2:0]   axi_id;
        axi_opt_t     src;
        axi_opt_t     dst;
        backend_opt_t beo;
        logic         last;
    } options_t;

    // Full backend request as seen by the iDMA backend.
    typedef struct packed {
        logic [31:0] length;
        logic [63:0] src_addr;
        logic [63:0] dst_addr;
        options_t    opt;
    } desc64_req_t;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_ISSUE   = 2'd2
    } desc_state_e;

endpackage

// File: rtl/idma_desc64_desc_decoder.sv
// desc64 descriptor decoder: collects the four R beats of one descriptor,
// decodes them into a backend request and hands the next pointer back to the
// fetch logic. Malformed or errored fetches are dropped with a one-cycle
// fetch_err_o pulse. One descriptor is in flight at a time.
//
// Optional feature: IDMA_DESC64_ZERO_LEN_SKIP_EN suppresses the backend
// request of zero-length descriptors (the next-pointer handover still runs).
//
// Handshakes: every valid/ready pair transfers on a rising edge where both
// are high; a valid, once raised, stays high with stable payload until that
// edge, and ready may be driven independently of valid.
module idma_desc64_desc_decoder
    import idma_desc64_pkg::*;
#(
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned TFLenWidth = 32,
    parameter type idma_req_t = idma_desc64_pkg::desc64_req_t
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DataWidth-1:0] r_data_i,
    input  logic                 r_last_i,
    input  logic                 r_err_i,
    input  logic                 r_valid_i,
    output logic                 r_ready_o,
    output idma_req_t            idma_req_o,
    output logic                 idma_req_valid_o,
    input  logic                 idma_req_ready_i,
    output logic                 irq_en_o,
    output logic [AddrWidth-1:0] next_addr_o,
    output logic                 next_valid_o,
    input  logic                 next_ready_i,
    output logic                 chain_end_o,
    output logic                 fetch_err_o,
    output desc_state_e          state_o
);

    desc_state_e          state_q, state_d;
    logic [1:0]           beat_cnt_q, beat_cnt_d;
    logic                 err_q, err_d;
    logic [DataWidth-1:0] slot_q [3];

    logic                 r_ready_q, r_ready_d;
    idma_req_t            req_q, req_d;
    logic                 req_valid_q, req_valid_d;
    logic                 req_done_q, req_done_d;
    logic                 irq_en_q, irq_en_d;
    logic [AddrWidth-1:0] next_addr_q, next_addr_d;
    logic                 next_valid_q, next_valid_d;
    logic                 next_done_q, next_done_d;
    logic                 chain_end_q, chain_end_d;
    logic                 fetch_err_q, fetch_err_d;

    idma_req_t            dec_req;
    logic                 dec_chain_end;
    logic                 dec_zero_len;
    logic                 beat_accept;
    logic                 req_hs;
    logic                 next_hs;

    // Flag bits above the defined ones are reserved and deliberately ignored.
    logic unused_flags;
    assign unused_flags = ^slot_q[BEAT_LEN][DataWidth-1:FLAGS_LSB+FLAGS_USED];

    assign beat_accept = r_valid_i && r_ready_q;
    assign req_hs      = req_valid_q && idma_req_ready_i;
    assign next_hs     = next_valid_q && next_ready_i;

    // Decode the three stored beats plus the beat-3 data currently on the bus.
    always_comb begin
        dec_req = '0;
        dec_req.length[TFLenWidth-1:0] = slot_q[BEAT_LEN][TFLenWidth-1:0];
        dec_req.src_addr = slot_q[BEAT_SRC];
        dec_req.dst_addr = r_data_i;
        dec_req.opt.src_protocol = PROT_AXI;
        dec_req.opt.dst_protocol = PROT_AXI;
        dec_req.opt.beo.decouple_rw = slot_q[BEAT_LEN][FLAGS_LSB + FLAG_DECOUPLE_RW];
        dec_req.opt.beo.decouple_aw = slot_q[BEAT_LEN][FLAGS_LSB + FLAG_DECOUPLE_AW];
        if (slot_q[BEAT_LEN][FLAGS_LSB + FLAG_BURST_FIXED]) begin
            dec_req.opt.src.burst = AXI_BURST_FIXED;
            dec_req.opt.dst.burst = AXI_BURST_FIXED;
        end else begin
            dec_req.opt.src.burst = AXI_BURST_INCR;
            dec_req.opt.dst.burst = AXI_BURST_INCR;
        end
        dec_chain_end = (slot_q[BEAT_NEXT] == END_OF_CHAIN);
        dec_zero_len  = (slot_q[BEAT_LEN][TFLenWidth-1:0] == '0);
    end

    // Next-state and next-output logic for the COLLECT / DRAIN / ISSUE FSM.
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        err_d        = err_q;
        req_d        = req_q;
        req_valid_d  = req_valid_q;
        req_done_d   = req_done_q;
        irq_en_d     = irq_en_q;
        next_addr_d  = next_addr_q;
        next_valid_d = next_valid_q;
        next_done_d  = next_done_q;
        chain_end_d  = chain_end_q;
        fetch_err_d  = 1'b0;

        case (state_q)
            ST_COLLECT: begin
                if (beat_accept) begin
                    if (beat_cnt_q != BEAT_LAST_IDX) begin
                        if (r_last_i) begin
                            // Burst ended early: drop it right away.
                            fetch_err_d = 1'b1;
                            beat_cnt_d  = '0;
                            err_d       = 1'b0;
                        end else begin
                            beat_cnt_d = beat_cnt_q + 2'd1;
                            if (r_err_i) err_d = 1'b1;
                        end
                    end else begin
                        beat_cnt_d = '0;
                        if (!r_last_i) begin
                            // Burst is too long; swallow the tail first.
                            err_d   = 1'b1;
                            state_d = ST_DRAIN;
                        end else if (err_q || r_err_i) begin
                            fetch_err_d = 1'b1;
                            err_d       = 1'b0;
                        end else begin
                            state_d      = ST_ISSUE;
                            req_d        = dec_req;
                            req_valid_d  = 1'b1;
                            req_done_d   = 1'b0;
                            irq_en_d     = slot_q[BEAT_LEN][FLAGS_LSB + FLAG_IRQ];
                            next_addr_d  = AddrWidth'(slot_q[BEAT_NEXT]);
                            chain_end_d  = dec_chain_end;
                            next_valid_d = !dec_chain_end;
                            next_done_d  = dec_chain_end;
`ifdef IDMA_DESC64_ZERO_LEN_SKIP_EN
                            if (dec_zero_len) begin
                                req_valid_d = 1'b0;
                                req_done_d  = 1'b1;
                            end
`endif
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (beat_accept && r_last_i) begin
                    fetch_err_d = 1'b1;
                    err_d       = 1'b0;
                    state_d     = ST_COLLECT;
                end
            end
            ST_ISSUE: begin
                if (req_hs) begin
                    req_valid_d = 1'b0;
                    req_done_d  = 1'b1;
                end
                if (next_hs) begin
                    next_valid_d = 1'b0;
                    next_done_d  = 1'b1;
                end
                if ((req_done_q || req_hs) && (next_done_q || next_hs)) begin
                    state_d     = ST_COLLECT;
                    req_done_d  = 1'b0;
                    next_done_d = 1'b0;
                    irq_en_d    = 1'b0;
                    chain_end_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase

        // R is accepted in every state except while a request is pending.
        r_ready_d = (state_d != ST_ISSUE);
    end

    // Control and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_COLLECT;
            beat_cnt_q   <= '0;
            err_q        <= 1'b0;
            r_ready_q    <= 1'b0;
            req_q        <= '0;
            req_valid_q  <= 1'b0;
            req_done_q   <= 1'b0;
            irq_en_q     <= 1'b0;
            next_addr_q  <= '0;
            next_valid_q <= 1'b0;
            next_done_q  <= 1'b0;
            chain_end_q  <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
            r_ready_q    <= r_ready_d;
            req_q        <= req_d;
            req_valid_q  <= req_valid_d;
            req_done_q   <= req_done_d;
            irq_en_q     <= irq_en_d;
            next_addr_q  <= next_addr_d;
            next_valid_q <= next_valid_d;
            next_done_q  <= next_done_d;
            chain_end_q  <= chain_end_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    // Beat slots 0-2 capture the stored words of the descriptor in flight.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_COLLECT && beat_accept) begin
            case (beat_cnt_q)
                2'd0:    slot_q[0] <= r_data_i;
                2'd1:    slot_q[1] <= r_data_i;
                2'd2:    slot_q[2] <= r_data_i;
                default: ;
            endcase
        end
    end

    assign r_ready_o        = r_ready_q;
    assign idma_req_o       = req_q;
    assign idma_req_valid_o = req_valid_q;
    assign irq_en_o         = irq_en_q;
    assign next_addr_o      = next_addr_q;
    assign next_valid_o     = next_valid_q;
    assign chain_end_o      = chain_end_q;
    assign fetch_err_o      = fetch_err_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_idma_desc64_desc_decoder.sv
// Bench for idma_desc64_desc_decoder: hand-written corner sequences plus a
// table of descriptors driven with random backend/fetch readies; requests and
// next pointers are checked against expectation queues by a monitor.
`timescale 1ns/1ps
module tb_idma_desc64_desc_decoder;
    import idma_desc64_pkg::*;

    localparam int RW = 168;
`ifdef IDMA_DESC64_ZERO_LEN_SKIP_EN
    localparam bit ZSKIP = 1'b1;
`else
    localparam bit ZSKIP = 1'b0;
`endif

    typedef struct {
        logic [31:0] len;
        logic [31:0] flags;
        logic [63:0] nxt;
        logic [63:0] src;
        logic [63:0] dst;
        int          err_beat;
        int          nbeats;
        bit          exp_issue;
        bit          exp_err;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] r_data = '0;
    logic        r_last = 1'b0;
    logic        r_err = 1'b0;
    logic        r_valid = 1'b0;
    logic        r_ready;
    desc64_req_t idma_req;
    logic        idma_req_valid;
    logic        idma_req_ready;
    logic        irq_en;
    logic [63:0] next_addr;
    logic        next_valid;
    logic        next_ready;
    logic        chain_end;
    logic        fetch_err;
    desc_state_e state;

    bit   rand_rdy = 1'b0;
    logic fix_req_rdy = 1'b1, fix_nxt_rdy = 1'b1;
    logic rnd_req_rdy = 1'b0, rnd_nxt_rdy = 1'b0;
    assign idma_req_ready = rand_rdy ? rnd_req_rdy : fix_req_rdy;
    assign next_ready     = rand_rdy ? rnd_nxt_rdy : fix_nxt_rdy;

    always #5 clk = ~clk;

    idma_desc64_desc_decoder dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .r_data_i        (r_data),
        .r_last_i        (r_last),
        .r_err_i         (r_err),
        .r_valid_i       (r_valid),
        .r_ready_o       (r_ready),
        .idma_req_o      (idma_req),
        .idma_req_valid_o(idma_req_valid),
        .idma_req_ready_i(idma_req_ready),
        .irq_en_o        (irq_en),
        .next_addr_o     (next_addr),
        .next_valid_o    (next_valid),
        .next_ready_i    (next_ready),
        .chain_end_o     (chain_end),
        .fetch_err_o     (fetch_err),
        .state_o         (state)
    );

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_req_rdy = 1'($urandom_range(0, 1));
            rnd_nxt_rdy = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [RW-1:0] exp_req_q[$];
    logic [63:0]   exp_next_q[$];
    int exp_err_cnt = 0;
    int obs_err_cnt = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    logic [RW-1:0] act_req;
    assign act_req = {idma_req.length, idma_req.src_addr, idma_req.dst_addr, irq_en,
                      idma_req.opt.beo.decouple_rw, idma_req.opt.beo.decouple_aw,
                      idma_req.opt.src.burst, idma_req.opt.dst.burst, chain_end};

    function automatic logic [RW-1:0] exp_pack(input vec_t v);
        logic [1:0] b;
        b = v.flags[3] ? 2'b00 : 2'b01;
        return {v.len, v.src, v.dst, v.flags[0], v.flags[1], v.flags[2], b, b,
                (v.nxt == 64'hFFFF_FFFF_FFFF_FFFF)};
    endfunction

    logic          prev_rv = 1'b0, prev_rr = 1'b0, prev_nv = 1'b0, prev_nr = 1'b0;
    logic [RW-1:0] prev_req = '0;
    logic [63:0]   prev_next = '0;

    // Monitor: sampled on the falling edge, handshakes complete at the next rise.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (fetch_err) obs_err_cnt++;
            if (prev_rv && !prev_rr) begin
                check("req_valid_held", idma_req_valid, 1'b1);
                check("req_data_stable", act_req, prev_req);
            end
            if (prev_nv && !prev_nr) begin
                check("next_valid_held", next_valid, 1'b1);
                check("next_addr_stable", next_addr, prev_next);
            end
            if (idma_req_valid || next_valid)
                check("no_next_valid_at_chain_end", next_valid && chain_end, 1'b0);
            if (idma_req_valid)
                check("r_ready_low_in_issue", r_ready, 1'b0);
            if (idma_req_valid && idma_req_ready) begin
                if (exp_req_q.size() == 0)
                    fail("unexpected_req", $sformatf("got req %0h, required none", act_req));
                else
                    check("req_data", act_req, exp_req_q.pop_front());
            end
            if (next_valid && next_ready) begin
                if (exp_next_q.size() == 0)
                    fail("unexpected_next", $sformatf("got next %0h, required none", next_addr));
                else
                    check("next_addr", next_addr, exp_next_q.pop_front());
            end
            prev_rv   = idma_req_valid;
            prev_rr   = idma_req_ready;
            prev_nv   = next_valid;
            prev_nr   = next_ready;
            prev_req  = act_req;
            prev_next = next_addr;
        end else begin
            prev_rv = 1'b0;
            prev_nv = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [63:0] d, input logic last, input logic err);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        r_data  = d;
        r_last  = last;
        r_err   = err;
        r_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = r_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) fail("beat_accept_timeout", "got no accept in 200 cycles, required accept");
        r_valid = 1'b0;
        r_last  = 1'b0;
        r_err   = 1'b0;
    endtask

    // Pushes the expected outcome, then drives the beats; returns #1 after the
    // edge that accepted the final beat.
    task automatic send_desc(input vec_t v);
        logic [63:0] beats[5];
        bit bad;
        beats[0] = {v.flags, v.len};
        beats[1] = v.nxt;
        beats[2] = v.src;
        beats[3] = v.dst;
        beats[4] = 64'hDEAD_BEEF_0BAD_F00D;
        bad = (v.err_beat >= 0 && v.err_beat < v.nbeats) || (v.nbeats != 4);
        if (bad) begin
            exp_err_cnt++;
        end else begin
            if (!(ZSKIP && v.len == 32'd0)) exp_req_q.push_back(exp_pack(v));
            if (v.nxt != 64'hFFFF_FFFF_FFFF_FFFF) exp_next_q.push_back(v.nxt);
        end
        for (int i = 0; i < v.nbeats; i++)
            send_beat(beats[i], 1'(i == v.nbeats - 1), 1'(i == v.err_beat));
    endtask

    function automatic vec_t mk(input logic [31:0] len, input logic [31:0] flags,
                                input logic [63:0] nxt, input logic [63:0] src,
                                input logic [63:0] dst, input int err_beat,
                                input int nbeats, input bit exp_issue, input bit exp_err);
        vec_t v;
        v.len = len; v.flags = flags; v.nxt = nxt; v.src = src; v.dst = dst;
        v.err_beat = err_beat; v.nbeats = nbeats; v.exp_issue = exp_issue; v.exp_err = exp_err;
        return v;
    endfunction

    // ---------------- test ----------------
    vec_t vecs[13];
    vec_t v;

    initial begin
        vecs[0]  = mk(32'h40, 32'h1, 64'h1000, 64'h2000, 64'h3000, -1, 4, 1'b1, 1'b0);
        vecs[1]  = mk(32'h80, 32'h0, 64'h1100, 64'h2100, 64'h3100, 2, 4, 1'b0, 1'b1);
        vecs[2]  = mk(32'h44, 32'h6, 64'h1200, 64'h2200, 64'h3200, -1, 4, 1'b1, 1'b0);
        vecs[3]  = mk(32'h48, 32'hABCD_EF08, 64'h1300, 64'h2300, 64'h3300, -1, 4, 1'b1, 1'b0);
        vecs[4]  = mk(32'h10, 32'h1, 64'h1400, 64'h2400, 64'h3400, -1, 5, 1'b0, 1'b1);
        vecs[5]  = mk(32'h20, 32'h3, 64'h1500, 64'h2500, 64'h3500, -1, 4, 1'b1, 1'b0);
        vecs[6]  = mk(32'h30, 32'h0, 64'h1600, 64'h2600, 64'h3600, -1, 2, 1'b0, 1'b1);
        vecs[7]  = mk(32'h34, 32'h0, 64'h1700, 64'h2700, 64'h3700, 0, 4, 1'b0, 1'b1);
        vecs[8]  = mk(32'h38, 32'h0, 64'h1800, 64'h2800, 64'h3800, 3, 4, 1'b0, 1'b1);
        vecs[9]  = mk(32'h0, 32'h1, 64'h5000, 64'h2900, 64'h3900, -1, 4, !ZSKIP, 1'b0);
        vecs[10] = mk(32'h0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2A00, 64'h3A00, -1, 4, !ZSKIP, 1'b0);
        vecs[11] = mk(32'hFFFF_FFFF, 32'h9, 64'h1B00, 64'h2B00, 64'h3B00, -1, 4, 1'b1, 1'b0);
        vecs[12] = mk(32'h100, 32'h4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2C00, 64'h3C00, -1, 4, 1'b1, 1'b0);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl_outputs", {r_ready, idma_req_valid, next_valid, fetch_err, chain_end, irq_en}, 6'b0);
        check("reset_next_addr", next_addr, 64'h0);
        check("reset_state", state, ST_COLLECT);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("r_ready_after_reset", r_ready, 1'b1);
        mon_en = 1'b1;

        // Clean descriptor, readies high: one issue cycle.
        send_desc(vecs[0]);
        check("clean_req_valid", idma_req_valid, 1'b1);
        check("clean_next_valid", next_valid, 1'b1);
        check("clean_state_issue", state, ST_ISSUE);
        check("clean_irq_en", irq_en, 1'b1);
        check("clean_next_addr", next_addr, 64'h1000);
        check("clean_length", idma_req.length, 32'h40);
        @(posedge clk);
        #1;
        check("clean_back_to_collect", state, ST_COLLECT);
        check("clean_r_ready_back", r_ready, 1'b1);

        // End of chain: request issues, next pointer is never offered.
        v = mk(32'h60, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h4000, 64'h4100, -1, 4, 1'b1, 1'b0);
        send_desc(v);
        check("eoc_chain_end", chain_end, 1'b1);
        check("eoc_next_valid", next_valid, 1'b0);
        check("eoc_req_valid", idma_req_valid, 1'b1);
        @(posedge clk);
        #1;
        check("eoc_back_to_collect", state, ST_COLLECT);

        // Backend stalls for 10 cycles; next handshake completes at once.
        fix_req_rdy = 1'b0;
        v = mk(32'h70, 32'h2, 64'h7000, 64'h7100, 64'h7200, -1, 4, 1'b1, 1'b0);
        send_desc(v);
        check("stall_first_valid", idma_req_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("stall_req_valid", idma_req_valid, 1'b1);
            check("stall_next_done", next_valid, 1'b0);
            check("stall_r_ready", r_ready, 1'b0);
        end
        fix_req_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release_collect", state, ST_COLLECT);

        // Reset in the middle of a descriptor: no error pulse.
        send_beat(64'h0000_0001_0000_0050, 1'b0, 1'b0);
        send_beat(64'h8000, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_fetch_err", fetch_err, 1'b0);
        check("midrst_r_ready", r_ready, 1'b0);
        check("midrst_state", state, ST_COLLECT);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_r_ready_back", r_ready, 1'b1);

        // Table of descriptors under random readies.
        rand_rdy = 1'b1;
        for (int i = 0; i < 13; i++) begin
            send_desc(vecs[i]);
            check($sformatf("vec%0d_issue", i), idma_req_valid, vecs[i].exp_issue);
            check($sformatf("vec%0d_fetch_err", i), fetch_err, vecs[i].exp_err);
        end

        // Random clean descriptors.
        for (int i = 0; i < 8; i++) begin
            v.len   = $urandom_range(0, 3) == 0 ? 32'h0 : $urandom;
            v.flags = $urandom;
            v.nxt   = $urandom_range(0, 3) == 0 ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            v.src   = {$urandom, $urandom};
            v.dst   = {$urandom, $urandom};
            v.err_beat = -1;
            v.nbeats = 4;
            v.exp_issue = !(ZSKIP && v.len == 32'h0);
            v.exp_err = 1'b0;
            send_desc(v);
            check($sformatf("rand%0d_issue", i), idma_req_valid, v.exp_issue);
        end

        // Drain and final accounting.
        rand_rdy = 1'b0;
        fix_req_rdy = 1'b1;
        fix_nxt_rdy = 1'b1;
        for (int i = 0; i < 200 && (exp_req_q.size() != 0 || exp_next_q.size() != 0 || state != ST_COLLECT); i++)
            @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("final_state", state, ST_COLLECT);
        check("req_queue_empty", exp_req_q.size(), 0);
        check("next_queue_empty", exp_next_q.size(), 0);
        check("fetch_err_count", obs_err_cnt, exp_err_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
